// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage RV32I core.
// It drives the E-stage forwarding selects and the per-stage stall and flush
// enables. It resolves load-use hazards, E-stage redirects and multi-cycle
// data-memory accesses in M. A two-state wait FSM with a timeout handles the
// memory accesses, and saturating counters track stalls and flushes.
//
// Memory handshake: MemReqM_i marks an access held in M. MemAckM_i completes
// it in the same cycle it is seen. While the request is open and unacked, the
// whole F..M pipeline holds. MemBusy_o is the FSM state: 1 means WAIT.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D_i,
    input  logic [4:0]       Rs2D_i,
    input  logic [4:0]       Rs1E_i,
    input  logic [4:0]       Rs2E_i,
    input  logic [4:0]       RdE_i,
    input  logic [1:0]       ResultSrcE_i,
    input  logic [1:0]       PCSrcE_i,
    input  logic [4:0]       RdM_i,
    input  logic [4:0]       RdW_i,
    input  logic             RegWriteM_i,
    input  logic             RegWriteW_i,
    input  logic             MemReqM_i,
    input  logic             MemAckM_i,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic             FlushW_o,
    output logic             MemBusy_o,
    output logic             MemErr_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    // waitCnt only needs to reach MEM_TIMEOUT-1.
    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] LP_WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_lw_stall;
    logic             w_redirect;
    logic             w_timeout_hit;
    logic             w_mem_stall;

    // Operand forwarding: the younger producer in M wins over W; x0 never forwards.
    always_comb begin
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == Rs1E_i)) begin
            ForwardAE_o = 2'b10;
        end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == Rs1E_i)) begin
            ForwardAE_o = 2'b01;
        end
        if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == Rs2E_i)) begin
            ForwardBE_o = 2'b10;
        end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == Rs2E_i)) begin
            ForwardBE_o = 2'b01;
        end
    end

    // Hazard terms. A timeout cycle acts as a forced ack, so it never stalls.
    assign w_lw_stall    = (ResultSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                           ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    assign w_redirect    = (PCSrcE_i != 2'b00);
    assign w_timeout_hit = (r_state == ST_WAIT) && (r_wait_cnt == LP_WAIT_LAST) && !MemAckM_i;
    assign w_mem_stall   = MemReqM_i && !MemAckM_i && !w_timeout_hit;

    // State register and wait counter; the counter is zero on every entry to WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Next-state logic for the memory wait FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mem_stall) w_state_nxt = ST_WAIT;
            ST_WAIT: if (MemAckM_i || w_timeout_hit) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stall/flush outputs by priority: memory stall, then redirect, then load-use.
    always_comb begin
        StallF_o  = 1'b0;
        StallD_o  = 1'b0;
        StallE_o  = 1'b0;
        StallM_o  = 1'b0;
        FlushD_o  = 1'b0;
        FlushE_o  = 1'b0;
        FlushW_o  = 1'b0;
        MemBusy_o = (r_state == ST_WAIT);
        if (w_mem_stall) begin
            // E holds, so a pending redirect or load-use is seen again on release.
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            FlushW_o = 1'b1;
        end else if (w_redirect) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
        end else if (w_lw_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
        end
    end

    // One-cycle error pulse in the cycle after a forced release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_timeout_hit;
        end
    end

    // Saturating performance counters: stall cycles and redirect flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (FlushD_o && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign MemErr_o   = r_mem_err;
    assign StallCnt_o = r_stall_cnt;
    assign FlushCnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios followed by random pipeline
// traffic, checked against a transaction-level reference model.
module tb_hazard_ctrl;

  localparam int MT   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0]    result_src_e, pcsrc_e;
  logic          reg_write_m, reg_write_w, mem_req, mem_ack;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w, mem_busy, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e), .RdE_i(rde),
    .ResultSrcE_i(result_src_e), .PCSrcE_i(pcsrc_e),
    .RdM_i(rdm), .RdW_i(rdw), .RegWriteM_i(reg_write_m), .RegWriteW_i(reg_write_w),
    .MemReqM_i(mem_req), .MemAckM_i(mem_ack),
    .ForwardAE_o(fwd_a), .ForwardBE_o(fwd_b),
    .StallF_o(stall_f), .StallD_o(stall_d), .StallE_o(stall_e), .StallM_o(stall_m),
    .FlushD_o(flush_d), .FlushE_o(flush_e), .FlushW_o(flush_w),
    .MemBusy_o(mem_busy), .MemErr_o(mem_err),
    .StallCnt_o(stall_cnt), .FlushCnt_o(flush_cnt)
  );

  // ---------------- scoreboard state ----------------
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_stall_cnt = 0;
  int   exp_flush_cnt = 0;
  logic exp_busy = 1'b0;
  logic exp_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Forwarding rule: the newest matching writer supplies the operand.
  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (reg_write_m && rdm != 0 && rdm == rs) return 2'b10;
    if (reg_write_w && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_pipe();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    result_src_e = 0; pcsrc_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  // Random pipeline contents; a small register range makes matches frequent.
  task automatic rand_pipe();
    rs1d = 5'($urandom_range(0, 7)); rs2d = 5'($urandom_range(0, 7));
    rs1e = 5'($urandom_range(0, 7)); rs2e = 5'($urandom_range(0, 7));
    rde  = 5'($urandom_range(0, 7)); rdm  = 5'($urandom_range(0, 7));
    rdw  = 5'($urandom_range(0, 7));
    reg_write_m  = 1'($urandom_range(0, 1));
    reg_write_w  = 1'($urandom_range(0, 1));
    result_src_e = 2'($urandom_range(0, 3));
    pcsrc_e      = (result_src_e == 2'b01) ? 2'b00 : 2'($urandom_range(0, 3));
  endtask

  // Checks one cycle (inputs already driven at the negedge), then advances
  // the model across the rising edge. mstall is the model's memory-stall term.
  task automatic step(input logic mstall);
    logic lw, redir;
    logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    #1;
    lw    = (result_src_e == 2'b01) && rde != 0 && (rde == rs1d || rde == rs2d);
    redir = (pcsrc_e != 2'b00);
    e_sf = 0; e_sd = 0; e_se = 0; e_sm = 0; e_fd = 0; e_fe = 0; e_fw = 0;
    if (mstall) begin
      e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fw = 1;
    end else if (redir) begin
      e_fd = 1; e_fe = 1;
    end else if (lw) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
    chk("fwd_a", fwd_a, exp_fwd(rs1e));
    chk("fwd_b", fwd_b, exp_fwd(rs2e));
    chk("stall_f", stall_f, e_sf);
    chk("stall_d", stall_d, e_sd);
    chk("stall_e", stall_e, e_se);
    chk("stall_m", stall_m, e_sm);
    chk("flush_d", flush_d, e_fd);
    chk("flush_e", flush_e, e_fe);
    chk("flush_w", flush_w, e_fw);
    chk("mem_busy", mem_busy, exp_busy);
    chk("mem_err", mem_err, exp_err);
    chk("stall_cnt", stall_cnt, exp_stall_cnt);
    chk("flush_cnt", flush_cnt, exp_flush_cnt);
    @(posedge clk);
    if (e_sf && exp_stall_cnt < CMAX) exp_stall_cnt++;
    if (e_fd && exp_flush_cnt < CMAX) exp_flush_cnt++;
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  // One memory access whose ack arrives lat cycles after the request. The
  // access stalls for min(lat, MT) cycles; only lat > MT ends in a timeout.
  task automatic mem_txn(input int lat);
    for (int k = 0; k <= MT; k++) begin
      rand_pipe();
      mem_req  = 1'b1;
      mem_ack  = (k == lat);
      exp_busy = (k >= 1);
      step((k < lat) && (k < MT));
      if (k == lat) break;
    end
    mem_req  = 1'b0;
    mem_ack  = 1'b0;
    exp_busy = 1'b0;
    exp_err  = (lat > MT);
  endtask

  task automatic idle_cycle();
    rand_pipe();
    mem_req  = 1'($urandom_range(0, 1));
    mem_ack  = mem_req ? 1'b1 : 1'($urandom_range(0, 1));
    exp_busy = 1'b0;
    step(1'b0);
  endtask

  // ---------------- directed steps, then random traffic ----------------
  initial begin
    clear_pipe();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", mem_busy, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    step(1'b0);

    // Forwarding: M has priority, RdM = 0 falls back to W.
    clear_pipe();
    reg_write_m = 1; reg_write_w = 1; rdm = 5; rdw = 5; rs1e = 5;
    #1 chk("tp_fwd_m", fwd_a, 2'b10);
    step(1'b0);
    rdm = 0;
    #1 chk("tp_fwd_w", fwd_a, 2'b01);
    step(1'b0);

    // Load-use: one stall/bubble, then clear; RdE = x0 never stalls.
    clear_pipe();
    result_src_e = 2'b01; rde = 7; rs2d = 7;
    #1 chk("tp_lw_stall", {stall_f, stall_d, flush_e}, 3'b111);
    step(1'b0);
    clear_pipe();
    #1 chk("tp_lw_after", {stall_f, stall_d, flush_e}, 3'b000);
    step(1'b0);
    result_src_e = 2'b01; rde = 0; rs2d = 0;
    #1 chk("tp_lw_x0", {stall_f, stall_d, flush_e}, 3'b000);
    step(1'b0);

    // JALR redirect flushes D/E and counts one flush.
    clear_pipe();
    pcsrc_e = 2'b10;
    #1 chk("tp_jalr_flush", {flush_d, flush_e}, 2'b11);
    step(1'b0);
    clear_pipe();
    #1 chk("tp_jalr_cnt", flush_cnt, 1);
    step(1'b0);

    // Memory ack after 3 cycles with a taken branch waiting in E.
    for (int k = 0; k <= 3; k++) begin
      clear_pipe();
      pcsrc_e = 2'b01; mem_req = 1; mem_ack = (k == 3);
      exp_busy = (k >= 1);
      #1 chk("tp_mem_flushd", flush_d, (k == 3));
      step(k < 3);
    end
    clear_pipe();
    exp_busy = 0;
    #1;
    chk("tp_mem_stall_cnt", stall_cnt, 4);
    chk("tp_mem_flush_cnt", flush_cnt, 2);
    step(1'b0);

    // Timeout: 4 stall cycles, release on the 5th, error pulse on the 6th.
    for (int k = 0; k <= MT; k++) begin
      clear_pipe();
      mem_req = 1;
      exp_busy = (k >= 1);
      step(k < MT);
    end
    clear_pipe();
    exp_busy = 0; exp_err = 1;
    #1;
    chk("tp_to_err", mem_err, 1);
    chk("tp_to_idle", mem_busy, 0);
    chk("tp_to_stall_cnt", stall_cnt, 8);
    step(1'b0);
    #1 chk("tp_to_err_once", mem_err, 0);
    step(1'b0);

    // Reset in the middle of a wait.
    clear_pipe();
    mem_req = 1;
    exp_busy = 0; step(1'b1);
    exp_busy = 1; step(1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_pipe();
    exp_busy = 0; exp_err = 0; exp_stall_cnt = 0; exp_flush_cnt = 0;
    #1;
    chk("tp_rst_busy", mem_busy, 0);
    chk("tp_rst_stall_cnt", stall_cnt, 0);
    chk("tp_rst_flush_cnt", flush_cnt, 0);
    step(1'b0);

    // Random traffic: idle cycles mixed with accesses of random latency;
    // the small counter width also exercises saturation.
    repeat (200) begin
      if ($urandom_range(0, 2) == 0) mem_txn($urandom_range(0, MT + 2));
      else idle_cycle();
    end
    clear_pipe();
    exp_busy = 0;
    step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. Sits beside the F/D/E/M/W pipeline registers. Produces the forwarding selects that feed the execute-stage ALU operand muxes, and the per-stage stall and flush enables. Handles load-use stalls, taken-branch/jump redirects from E, and multi-cycle data-memory accesses in M via a wait FSM with timeout. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MEM_TIMEOUT, default 16: number of consecutive WAIT cycles after which the access is force-completed.
- CNT_W, default 32: width of the performance counters.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- Rs1D_i, Rs2D_i, input, 5 each: source registers of the instruction in D.
- Rs1E_i, Rs2E_i, RdE_i, input, 5 each: source and destination registers of the instruction in E.
- ResultSrcE_i, input, 2: 2'b01 marks a load in E.
- PCSrcE_i, input, 2: E-stage redirect; 2'b00 means no redirect, anything else means taken branch, JAL or JALR.
- RdM_i, RdW_i, input, 5 each: destination registers of the instructions in M and W.
- RegWriteM_i, RegWriteW_i, input, 1 each: register-write enables of the instructions in M and W.
- MemReqM_i, input, 1: the instruction in M is a load or store.
- MemAckM_i, input, 1: data memory completes the access this cycle.
- ForwardAE_o, ForwardBE_o, output, 2 each: operand select. 00 selects the RD1E/RD2E value, 10 selects ALUResultM, 01 selects ResultW.
- StallF_o, StallD_o, StallE_o, StallM_o, output, 1 each: hold the corresponding pipeline register.
- FlushD_o, FlushE_o, FlushW_o, output, 1 each: load a bubble into the D/E/W register.
- MemBusy_o, output, 1: FSM is in WAIT.
- MemErr_o, output, 1: registered one-cycle pulse on timeout.
- StallCnt_o, FlushCnt_o, output, CNT_W each: saturating counters.

## Operation
- **Forwarding** (combinational, per operand X ∈ {1,2}):
  - 10 if RegWriteM_i and RdM_i != 0 and RdM_i == RsXE_i.
  - Otherwise 01 if RegWriteW_i and RdW_i != 0 and RdW_i == RsXE_i.
  - Otherwise 00.
  - M takes priority over W.
  - Forward selects are not gated by stalls.
- **lwStall** = (ResultSrcE_i == 2'b01) and RdE_i != 0 and (RdE_i == Rs1D_i or RdE_i == Rs2D_i).
- **redirect** = (PCSrcE_i != 2'b00).
- lwStall and redirect are mutually exclusive, because a load cannot also redirect. No arbitration is needed between them.
- **memStall** = MemReqM_i and not MemAckM_i and not timeoutHit. memStall applies in both FSM states.
- **FSM states**: IDLE and WAIT.
  - IDLE → WAIT when memStall.
  - WAIT → IDLE when MemAckM_i or timeoutHit.
  - WAIT stays in WAIT otherwise.
- **Timeout**:
  - waitCnt clears on entry to WAIT and increments each WAIT cycle.
  - timeoutHit = (state == WAIT) and (waitCnt == MEM_TIMEOUT-1) and not MemAckM_i.
  - A timeout cycle behaves as a forced ack: no stall, the M instruction advances, and MemErr_o = 1 on the next cycle.
- **Output priority**:
  1. memStall:
     - StallF/D/E/M = 1 and FlushW = 1.
     - FlushD = FlushE = 0, so a pending redirect or lwStall is deferred until release. E holds and its redirect is re-evaluated then.
  2. redirect: FlushD = FlushE = 1; all stalls 0.
  3. lwStall: StallF = StallD = 1 and FlushE = 1.
  4. Otherwise: all stall and flush outputs 0.
- **Counters**:
  - StallCnt_o increments on any cycle where StallF_o = 1.
  - FlushCnt_o increments on any cycle where redirect causes FlushD_o = 1.
  - Both saturate at all-ones with no wrap.
- **Reset** (rst_n low at a clock edge):
  - state = IDLE, waitCnt = 0, MemErr_o = 0, counters = 0.
  - Reset mid-WAIT aborts the wait immediately.
  - Combinational outputs follow the input equations in the cycle after reset, with state = IDLE.

## Timing
- Forward, stall and flush outputs are combinational from inputs and state, with zero-cycle latency.
- A single-cycle access (req and ack in the same cycle) causes no stall and no state change.
- Access acked N cycles after the request, with N < MEM_TIMEOUT:
  - Stalls are high for exactly N cycles and drop in the ack cycle.
  - MemBusy_o is high for N cycles, starting one cycle after the request.
- Timeout:
  - Stalls are high for MEM_TIMEOUT cycles; the MEM_TIMEOUT+1-th cycle is the forced release.
  - MemErr_o is high on the following cycle only.
- Ack and timeout in the same cycle: ack wins and there is no MemErr_o.
- Load-use costs exactly one bubble, since E is flushed and the dependent instruction advances a cycle later.
- A redirect costs a two-instruction flush.

## Test plan
- ADD x5 in M, ADD x5 in W, Rs1E = 5, RegWrite on both → ForwardAE = 10. With RdM = 0 instead → ForwardAE = 01.
- Load to x7 in E, Rs2D = 7 → StallF = StallD = FlushE = 1 for one cycle, then all 0. With RdE = 0 → no stall.
- PCSrcE = 10 (JALR) → FlushD = FlushE = 1 and FlushCnt_o increments by 1.
- MemReqM held, ack 3 cycles later, with a taken branch in E → stalls plus FlushW for 3 cycles and no flush of D/E. The redirect flush fires in the release cycle; StallCnt_o increments by 3.
- MEM_TIMEOUT = 4, no ack → stalls for 4 cycles, release on the 5th, MemErr_o pulses once on the 6th, FSM back in IDLE.
- rst_n low during WAIT → next cycle state IDLE, counters 0, MemBusy_o = 0.
